// File: rtl/jtcontra_gfx_romarb.sv
// Shares one SDRAM read slot between the gfx1/gfx2 ROM ports, one-word cache per port.
// Define JTCONTRA_ROMARB_STATS_EN to add grant/timeout statistics outputs.
module jtcontra_gfx_romarb #(
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned TW      = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        gfx1_cs,
  input  logic [17:0] gfx1_addr,
  output logic [15:0] gfx1_data,
  output logic        gfx1_ok,
  input  logic        gfx2_cs,
  input  logic [17:0] gfx2_addr,
  output logic [15:0] gfx2_data,
  output logic        gfx2_ok,
  output logic        sdram_cs,
  output logic [18:0] sdram_addr,
  input  logic [15:0] sdram_data,
  input  logic        sdram_ok
`ifdef JTCONTRA_ROMARB_STATS_EN
  ,
  output logic [15:0] stat_grants1,
  output logic [15:0] stat_grants2,
  output logic [7:0]  stat_timeouts
`endif
);

  typedef enum logic [1:0] {StIdle, StBusy, StGap} state_t;

  state_t        r_state;
  logic          r_sdram_cs;
  logic [18:0]   r_sdram_addr;
  logic [17:0]   r_pend_tag;
  logic          r_last;
  logic [TW-1:0] r_cnt;
  logic          r_valid1, r_valid2;
  logic [17:0]   r_tag1, r_tag2;
  logic [15:0]   r_data1, r_data2;

  logic          w_hit1, w_hit2, w_miss1, w_miss2, w_req, w_sel, w_cnt_last;
  logic [17:0]   w_sel_addr;

  always_comb begin
    w_hit1     = r_valid1 & (r_tag1 == gfx1_addr);
    w_hit2     = r_valid2 & (r_tag2 == gfx2_addr);
    w_miss1    = gfx1_cs & ~w_hit1;
    w_miss2    = gfx2_cs & ~w_hit2;
    w_req      = w_miss1 | w_miss2;
    // On a tie the requester that was not served last wins
    w_sel      = (w_miss1 & w_miss2) ? ~r_last : w_miss2;
    w_sel_addr = w_sel ? gfx2_addr : gfx1_addr;
    w_cnt_last = (r_cnt == TW'(TIMEOUT - 1));
  end

  assign gfx1_ok    = gfx1_cs & w_hit1;
  assign gfx2_ok    = gfx2_cs & w_hit2;
  assign gfx1_data  = r_data1;
  assign gfx2_data  = r_data2;
  assign sdram_cs   = r_sdram_cs;
  assign sdram_addr = r_sdram_addr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= StIdle;
      r_sdram_cs   <= 1'b0;
      r_sdram_addr <= '0;
      r_pend_tag   <= '0;
      r_last       <= 1'b1;
      r_cnt        <= '0;
      r_valid1     <= 1'b0;
      r_valid2     <= 1'b0;
      r_tag1       <= '0;
      r_tag2       <= '0;
      r_data1      <= '0;
      r_data2      <= '0;
    end else begin
      case (r_state)
        StIdle: begin
          if (w_req) begin
            r_sdram_addr <= {w_sel, w_sel_addr};
            r_sdram_cs   <= 1'b1;
            r_pend_tag   <= w_sel_addr;
            if (w_sel) r_valid2 <= 1'b0;
            else       r_valid1 <= 1'b0;
            r_last       <= w_sel;
            r_cnt        <= '0;
            r_state      <= StBusy;
          end
        end
        StBusy: begin
          // r_last holds the requester owning the fetch in flight
          if (sdram_ok) begin
            if (r_last) begin
              r_data2  <= sdram_data;
              r_tag2   <= r_pend_tag;
              r_valid2 <= 1'b1;
            end else begin
              r_data1  <= sdram_data;
              r_tag1   <= r_pend_tag;
              r_valid1 <= 1'b1;
            end
            r_sdram_cs <= 1'b0;
            r_state    <= StGap;
          end else if (w_cnt_last) begin
            r_sdram_cs <= 1'b0;
            r_state    <= StGap;
          end else begin
            r_cnt <= r_cnt + TW'(1);
          end
        end
        StGap:   r_state <= StIdle;
        default: r_state <= StIdle;
      endcase
    end
  end

`ifdef JTCONTRA_ROMARB_STATS_EN
  logic        w_grant, w_tmo;
  logic [15:0] r_grants1, r_grants2;
  logic [7:0]  r_timeouts;

  assign w_grant = (r_state == StIdle) & w_req;
  assign w_tmo   = (r_state == StBusy) & ~sdram_ok & w_cnt_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_grants1  <= '0;
      r_grants2  <= '0;
      r_timeouts <= '0;
    end else begin
      if (w_grant && !w_sel && r_grants1 != '1) r_grants1 <= r_grants1 + 16'd1;
      if (w_grant &&  w_sel && r_grants2 != '1) r_grants2 <= r_grants2 + 16'd1;
      if (w_tmo && r_timeouts != '1)            r_timeouts <= r_timeouts + 8'd1;
    end
  end

  assign stat_grants1  = r_grants1;
  assign stat_grants2  = r_grants2;
  assign stat_timeouts = r_timeouts;
`endif

endmodule

// File: tb/tb_jtcontra_gfx_romarb.sv
// Bench for jtcontra_gfx_romarb: directed scenarios plus random traffic against a cache model.
module tb_jtcontra_gfx_romarb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        gfx1_cs, gfx2_cs;
  logic [17:0] gfx1_addr, gfx2_addr;
  logic [15:0] gfx1_data, gfx2_data;
  logic        gfx1_ok, gfx2_ok;
  logic        sdram_cs;
  logic [18:0] sdram_addr;
  logic [15:0] sdram_data;
  logic        sdram_ok;
`ifdef JTCONTRA_ROMARB_STATS_EN
  logic [15:0] stat_grants1, stat_grants2;
  logic [7:0]  stat_timeouts;
`endif

  always #5 clk = ~clk;

  jtcontra_gfx_romarb dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .gfx1_cs    (gfx1_cs),
    .gfx1_addr  (gfx1_addr),
    .gfx1_data  (gfx1_data),
    .gfx1_ok    (gfx1_ok),
    .gfx2_cs    (gfx2_cs),
    .gfx2_addr  (gfx2_addr),
    .gfx2_data  (gfx2_data),
    .gfx2_ok    (gfx2_ok),
    .sdram_cs   (sdram_cs),
    .sdram_addr (sdram_addr),
    .sdram_data (sdram_data),
    .sdram_ok   (sdram_ok)
`ifdef JTCONTRA_ROMARB_STATS_EN
    ,
    .stat_grants1  (stat_grants1),
    .stat_grants2  (stat_grants2),
    .stat_timeouts (stat_timeouts)
`endif
  );

  int checks   = 0;
  int failures = 0;

  // Reference: what each requester's cache should hold, updated per SDRAM transaction
  logic        mv[2];
  logic [17:0] mtag[2];
  logic [15:0] mdat[2];
  logic        prev_cs, prev_ok;
  logic [18:0] prev_addr;
  int          lat;
  int          rcnt;
  int          hold[2];
  logic [17:0] hold_addr[2];
  bit          live_en;

  function automatic logic [15:0] memf(input logic [18:0] a);
    if (a == 19'h00123) return 16'hBEEF;
    return 16'(a[15:0] * 16'd40503) ^ {a[18:16], 13'h1B3};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    mv[0] = 1'b0; mv[1] = 1'b0;
    prev_cs = 1'b0; prev_ok = 1'b0; prev_addr = '0;
    rcnt = 0; sdram_ok = 1'b0; sdram_data = '0;
    hold[0] = 0; hold[1] = 0;
  endtask

  // One clock: update model for the edge just passed, check, then play the SDRAM side
  task automatic cycle();
    logic       cs_now[2];
    logic       ok_now[2];
    logic [17:0] a_now[2];
    @(negedge clk);
    if (prev_cs && prev_ok) begin
      mv[prev_addr[18]]   = 1'b1;
      mtag[prev_addr[18]] = prev_addr[17:0];
      mdat[prev_addr[18]] = memf(prev_addr);
    end
    if (sdram_cs && !prev_cs) mv[sdram_addr[18]] = 1'b0;
    chk("gfx1_ok", gfx1_ok, gfx1_cs & mv[0] & (mtag[0] == gfx1_addr));
    chk("gfx2_ok", gfx2_ok, gfx2_cs & mv[1] & (mtag[1] == gfx2_addr));
    if (gfx1_ok) chk("gfx1_data", gfx1_data, mdat[0]);
    if (gfx2_ok) chk("gfx2_data", gfx2_data, mdat[1]);
    cs_now = '{gfx1_cs, gfx2_cs};
    ok_now = '{gfx1_ok, gfx2_ok};
    a_now  = '{gfx1_addr, gfx2_addr};
    for (int i = 0; i < 2; i++) begin
      if (cs_now[i] && !ok_now[i] && a_now[i] == hold_addr[i]) hold[i]++;
      else hold[i] = 0;
      hold_addr[i] = a_now[i];
      if (live_en) chk("wait_bound", hold[i] > 40, 0);
    end
    prev_cs   = sdram_cs;
    prev_addr = sdram_addr;
    if (sdram_cs) begin
      if (rcnt >= lat) begin
        sdram_ok   = 1'b1;
        sdram_data = memf(sdram_addr);
      end else begin
        sdram_ok = 1'b0;
        rcnt++;
      end
    end else begin
      sdram_ok = 1'b0;
      rcnt     = 0;
    end
    prev_ok = sdram_ok;
  endtask

  task automatic wait_cs(input logic level, input int bound);
    int n = 0;
    while (sdram_cs !== level && n < bound) begin
      cycle();
      n++;
    end
    chk("wait_sdram_cs", sdram_cs, level);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    gfx1_cs = 1'b0; gfx2_cs = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int          sels[$];
    int          lowrun;
    int          n;
    logic        lastc;
    logic [17:0] pool[4];
    pool = '{18'h00010, 18'h00011, 18'h3FFFF, 18'h20000};
    rst_n = 1'b0; live_en = 1'b0; lat = 0;
    gfx1_cs = 1'b1; gfx1_addr = '0; gfx2_cs = 1'b1; gfx2_addr = '0;
    hold_addr[0] = '0; hold_addr[1] = '0;
    model_reset();

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_sdram_cs", sdram_cs, 0);
    chk("rst_sdram_addr", sdram_addr, 0);
    chk("rst_gfx1_ok", gfx1_ok, 0);
    chk("rst_gfx2_ok", gfx2_ok, 0);
    chk("rst_gfx1_data", gfx1_data, 0);
    chk("rst_gfx2_data", gfx2_data, 0);
`ifdef JTCONTRA_ROMARB_STATS_EN
    chk("rst_stat_g1", stat_grants1, 0);
    chk("rst_stat_tmo", stat_timeouts, 0);
`endif
    gfx1_cs = 1'b0; gfx2_cs = 1'b0;
    rst_n = 1'b1;

    // Single miss with a two-cycle SDRAM response
    cycle();
    gfx1_cs = 1'b1; gfx1_addr = 18'h00123; lat = 2;
    cycle();
    chk("t1_cs", sdram_cs, 1);
    chk("t1_addr", sdram_addr, 19'h00123);
    cycle(); cycle();
    chk("t1_ok_early", gfx1_ok, 0);
    cycle();
    chk("t1_ok", gfx1_ok, 1);
    chk("t1_data", gfx1_data, 16'hBEEF);
    for (int i = 0; i < 8; i++) begin
      cycle();
      chk("t1_hold_ok", gfx1_ok, 1);
      chk("t1_no_cs", sdram_cs, 0);
    end

    // Both requesters missing continuously: strict alternation
    do_reset();
    gfx1_cs = 1'b1; gfx1_addr = 18'h00040;
    gfx2_cs = 1'b1; gfx2_addr = 18'h00080;
    lat = 0; lowrun = 0; lastc = 1'b0;
    for (int i = 0; i < 60 && sels.size() < 4; i++) begin
      cycle();
      if (sdram_cs && !lastc) begin
        if (sels.size() > 0) chk("t2_gap", lowrun >= 2, 1);
        chk("t2_addr", sdram_addr[17:0], sdram_addr[18] ? gfx2_addr : gfx1_addr);
        sels.push_back(int'(sdram_addr[18]));
      end
      lowrun = sdram_cs ? 0 : lowrun + 1;
      lastc  = sdram_cs;
      if (gfx1_ok) gfx1_addr = gfx1_addr + 18'd1;
      if (gfx2_ok) gfx2_addr = gfx2_addr + 18'd1;
    end
    chk("t2_grants", sels.size(), 4);
    for (int k = 0; k < sels.size(); k++) chk("t2_sel", sels[k], k % 2);

    // Address change mid-fetch
    gfx1_cs = 1'b0; gfx2_cs = 1'b0;
    wait_cs(1'b0, 10);
    cycle(); cycle();
    gfx2_cs = 1'b1; gfx2_addr = 18'h3FFFF; lat = 3;
    wait_cs(1'b1, 10);
    chk("t3_addr1", sdram_addr, 19'h7FFFF);
    gfx2_addr = 18'h00001;
    n = 0;
    while (sdram_cs && n < 20) begin
      cycle(); n++;
      chk("t3_ok_low", gfx2_ok, 0);
    end
    wait_cs(1'b1, 10);
    chk("t3_addr2", sdram_addr, 19'h40001);
    n = 0;
    while (!gfx2_ok && n < 20) begin cycle(); n++; end
    chk("t3_ok2", gfx2_ok, 1);
    chk("t3_data2", gfx2_data, memf(19'h40001));

    // No sdram_ok: timeout, one gap, reissue
    gfx2_cs = 1'b0;
    cycle();
    gfx1_cs = 1'b1; gfx1_addr = 18'h00777; lat = 1000;
    wait_cs(1'b1, 10);
    n = 0;
    while (sdram_cs && n < 200) begin cycle(); n++; end
    chk("t4_busy_len", n, 64);
    n = 0;
    while (!sdram_cs && n < 10) begin cycle(); n++; end
    chk("t4_low_len", n, 2);
    chk("t4_reissue", sdram_addr, 19'h00777);
`ifdef JTCONTRA_ROMARB_STATS_EN
    chk("t4_stat_tmo", stat_timeouts, 1);
`endif
    lat = 0;
    n = 0;
    while (!gfx1_ok && n < 10) begin cycle(); n++; end
    chk("t4_ok", gfx1_ok, 1);

    // sdram_ok on the last counted cycle: ok wins
    gfx1_addr = 18'h00888; lat = 63;
    wait_cs(1'b1, 10);
    n = 0;
    while (sdram_cs && n < 200) begin cycle(); n++; end
    chk("t5_busy_len", n, 64);
    chk("t5_ok", gfx1_ok, 1);
    chk("t5_data", gfx1_data, memf(19'h00888));
`ifdef JTCONTRA_ROMARB_STATS_EN
    chk("t5_stat_tmo", stat_timeouts, 1);
`endif

    // Reset pulse during BUSY
    gfx2_cs = 1'b1; gfx2_addr = 18'h00001;
    cycle();
    chk("t6_gfx2_hit", gfx2_ok, 1);
    gfx1_addr = 18'h00999; lat = 1000;
    wait_cs(1'b1, 10);
    chk("t6_sel", sdram_addr[18], 0);
    gfx2_addr = 18'h00002;
    #2 rst_n = 1'b0;
    #1;
    chk("t6_cs_rst", sdram_cs, 0);
    chk("t6_ok1_rst", gfx1_ok, 0);
    chk("t6_ok2_rst", gfx2_ok, 0);
    @(negedge clk);
    model_reset();
    rst_n = 1'b1;
    sdram_ok = 1'b1;
    sdram_data = 16'hDEAD;
    lat = 0;
    cycle();
    chk("t6_first_grant_cs", sdram_cs, 1);
    chk("t6_first_grant_sel", sdram_addr, 19'h00999);
    for (int i = 0; i < 10; i++) cycle();

    // Random traffic against the cache model
    live_en = 1'b1;
    for (int i = 0; i < 600; i++) begin
      cycle();
      if ($urandom_range(0, 3) == 0) gfx1_cs = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) gfx2_cs = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 5) == 0) gfx1_addr = pool[$urandom_range(0, 3)];
      if ($urandom_range(0, 5) == 0) gfx2_addr = pool[$urandom_range(0, 3)];
      if (!sdram_cs) lat = $urandom_range(0, 4);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
